// File: rtl/imul_sequencer.sv
// Multi-cycle unsigned shift-add multiplier for IMUL: one partial-product step per clock,
// one-cycle done strobe with product and destination, and a stall request while busy.
module imul_sequencer #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 5
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 iStart,
    input  logic [WIDTH-1:0]     iA,
    input  logic [WIDTH-1:0]     iB,
    input  logic [7:0]           iDestination,
    output logic                 oStall,
    output logic                 oBusy,
    output logic                 oDone,
    output logic [2*WIDTH-1:0]   oProduct,
    output logic [7:0]           oDestination
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_t               r_state;
    state_t               w_next;
    logic [CNT_W-1:0]     r_count;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   r_acc;
    logic [7:0]           r_dest;
    logic [2*WIDTH-1:0]   w_acc_next;
    logic                 w_accept;
    logic                 w_last;

    always_ff @(posedge Clock) begin
        if (Reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_last   = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                w_accept = iStart;
                w_next   = iStart ? S_RUN : S_IDLE;
            end
            S_RUN: begin
                w_last = (r_count == LAST_STEP);
                if (w_last) w_next = S_DONE;
            end
            default: w_next = S_IDLE;
        endcase
        // Decode freezes in the very cycle it issues, before the state register sees the start.
        oStall = (r_state == S_RUN) || w_accept;
        oBusy  = (r_state == S_RUN);
        oDone  = (r_state == S_DONE);
    end

    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_count      <= '0;
            r_mcand      <= '0;
            r_mplier     <= '0;
            r_acc        <= '0;
            r_dest       <= '0;
            oProduct     <= '0;
            oDestination <= '0;
        end else if (w_accept) begin
            r_count  <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, iA};
            r_mplier <= iB;
            r_acc    <= '0;
            r_dest   <= iDestination;
        end else if (r_state == S_RUN) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count + 1'b1;
            if (w_last) begin
                oProduct     <= w_acc_next;
                oDestination <= r_dest;
            end
        end
    end

endmodule

// File: tb/tb_imul_sequencer.sv
// Directed bench for imul_sequencer: stimulus pushes expected write-backs into a queue,
// a forked monitor pops and compares on every oDone; control timing is checked inline.
module tb_imul_sequencer;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        iStart;
    logic [15:0] iA;
    logic [15:0] iB;
    logic [7:0]  iDestination;
    logic        oStall;
    logic        oBusy;
    logic        oDone;
    logic [31:0] oProduct;
    logic [7:0]  oDestination;

    typedef struct {
        logic [31:0] prod;
        logic [7:0]  dest;
        int unsigned cyc;
    } exp_t;

    exp_t        q[$];
    int unsigned cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    int unsigned n_done = 0;

    imul_sequencer #(.WIDTH(16), .CNT_W(5)) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .iStart       (iStart),
        .iA           (iA),
        .iB           (iB),
        .iDestination (iDestination),
        .oStall       (oStall),
        .oBusy        (oBusy),
        .oDone        (oDone),
        .oProduct     (oProduct),
        .oDestination (oDestination)
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge Clock);
            if (oDone === 1'b1) begin
                n_done++;
                if (q.size() == 0) begin
                    check("unexpected_done", 64'(oProduct), 64'hDEAD);
                end else begin
                    e = q.pop_front();
                    check("product", 64'(oProduct), 64'(e.prod));
                    check("destination", 64'(oDestination), 64'(e.dest));
                    check("done_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic next_cyc();
        @(posedge Clock);
        #1;
    endtask

    // Drive a start in the current cycle; stall must rise combinationally.
    task automatic issue_now(input logic [15:0] a, input logic [15:0] b, input logic [7:0] d,
                             input logic [31:0] prod, input bit expect_done);
        exp_t e;
        iStart = 1'b1;
        iA = a;
        iB = b;
        iDestination = d;
        #2;
        check("stall_on_issue", 64'(oStall), 64'd1);
        if (expect_done) begin
            e.prod = prod;
            e.dest = d;
            e.cyc  = cyc + 17;
            q.push_back(e);
        end
    endtask

    task automatic run_cycles(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) next_cyc();
    endtask

    int unsigned busy_cnt;
    int unsigned stall_cnt;
    int unsigned done_before;

    initial begin
        Reset = 1'b1;
        iStart = 1'b0;
        iA = '0;
        iB = '0;
        iDestination = '0;
        fork
            monitor();
        join_none

        // Reset state
        run_cycles(3);
        #2;
        check("rst_busy", 64'(oBusy), 64'd0);
        check("rst_stall", 64'(oStall), 64'd0);
        check("rst_done", 64'(oDone), 64'd0);
        check("rst_product", 64'(oProduct), 64'd0);
        check("rst_dest", 64'(oDestination), 64'd0);
        next_cyc();
        Reset = 1'b0;

        // 7 x 5 -> R3: 16 busy cycles, stall low in DONE
        next_cyc();
        issue_now(16'd7, 16'd5, 8'h03, 32'd35, 1'b1);
        busy_cnt = 0;
        stall_cnt = 0;
        for (int unsigned i = 0; i < 16; i++) begin
            next_cyc();
            iStart = 1'b0;
            #2;
            if (oBusy === 1'b1) busy_cnt++;
            if (oStall === 1'b1) stall_cnt++;
        end
        check("busy_cycles", 64'(busy_cnt), 64'd16);
        check("stall_cycles", 64'(stall_cnt), 64'd16);
        next_cyc();
        #2;
        check("done_cycle_stall", 64'(oStall), 64'd0);
        check("done_cycle_busy", 64'(oBusy), 64'd0);
        check("done_strobe", 64'(oDone), 64'd1);
        run_cycles(2);

        // All-ones operands
        issue_now(16'hFFFF, 16'hFFFF, 8'h05, 32'hFFFE0001, 1'b1);
        next_cyc();
        iStart = 1'b0;
        run_cycles(19);

        // Zero multiplier keeps full latency
        issue_now(16'h1234, 16'h0000, 8'h07, 32'd0, 1'b1);
        next_cyc();
        iStart = 1'b0;
        run_cycles(19);

        // 3 x 4 with a start pulse during RUN cycle 5 that must be ignored
        done_before = n_done;
        issue_now(16'd3, 16'd4, 8'h02, 32'd12, 1'b1);
        next_cyc();
        iStart = 1'b0;
        run_cycles(4);
        iStart = 1'b1;
        iA = 16'd9;
        iB = 16'd9;
        iDestination = 8'h09;
        #2;
        check("stall_in_run", 64'(oStall), 64'd1);
        next_cyc();
        iStart = 1'b0;
        run_cycles(20);
        check("single_done", 64'(n_done - done_before), 64'd1);

        // 100 x 200 aborted by reset in RUN cycle 8
        done_before = n_done;
        issue_now(16'd100, 16'd200, 8'h04, 32'd20000, 1'b0);
        next_cyc();
        iStart = 1'b0;
        run_cycles(7);
        Reset = 1'b1;
        next_cyc();
        Reset = 1'b0;
        #2;
        check("abort_busy", 64'(oBusy), 64'd0);
        check("abort_stall", 64'(oStall), 64'd0);
        check("abort_product", 64'(oProduct), 64'd0);
        check("abort_done", 64'(oDone), 64'd0);
        run_cycles(20);
        check("abort_no_done", 64'(n_done - done_before), 64'd0);

        // Back-to-back: 6 x 7 then 11 x 13 issued in the DONE cycle
        issue_now(16'd6, 16'd7, 8'h01, 32'd42, 1'b1);
        next_cyc();
        iStart = 1'b0;
        run_cycles(16);
        #2;
        check("b2b_first_done", 64'(oDone), 64'd1);
        issue_now(16'd11, 16'd13, 8'h06, 32'd143, 1'b1);
        stall_cnt = 0;
        for (int unsigned i = 0; i < 16; i++) begin
            next_cyc();
            iStart = 1'b0;
            #2;
            if (oStall === 1'b1) stall_cnt++;
        end
        check("b2b_stall_cycles", 64'(stall_cnt), 64'd16);
        next_cyc();
        #2;
        check("b2b_second_done", 64'(oDone), 64'd1);
        run_cycles(3);

        check("queue_drained", 64'(q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/imul_sequencer.md
# imul_sequencer

Multi-cycle unsigned multiplier with its own controller. It executes the `IMUL` opcode for the processor datapath. On a start pulse from instruction decode it latches both source operands and the destination register code. It then runs one shift-add step per clock and raises a one-cycle done strobe with the product and destination for write-back. While a multiply is in flight it stalls the fetch/decode stage, so the ROM-driven program counter does not advance.

## Interface
- WIDTH, 16, operand width in bits; product is 2*WIDTH bits.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W > WIDTH.
- Clock  in  1  single system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- iStart  in  1  decode asserts for one cycle when an `IMUL` is issued.
- iA  in  WIDTH  multiplicand (Src1 register value), sampled when start is accepted.
- iB  in  WIDTH  multiplier (Src2 register value), sampled when start is accepted.
- iDestination  in  8  destination register code, sampled when start is accepted.
- oStall  out  1  processor hold request (combinational; see Operation).
- oBusy  out  1  high while a multiply is in progress (RUN state).
- oDone  out  1  one-cycle strobe: oProduct and oDestination are valid for write-back.
- oProduct  out  2*WIDTH  unsigned product, held until the next accepted start.
- oDestination  out  8  latched destination code, held with oProduct.

## Operation
- States: IDLE, RUN, DONE.
- Reset: state=IDLE; counter=0; oBusy=0; oDone=0; oProduct=0; oDestination=0; internal operand and accumulator registers=0.
- IDLE or DONE with iStart=1: start is accepted.
  - Latch iA into the multiplicand register, zero-extended to 2*WIDTH.
  - Latch iB into the multiplier shift register and iDestination.
  - Clear the accumulator and counter=0.
  - Next state is RUN.
- RUN, each cycle:
  - If multiplier[0]=1, accumulator += multiplicand, computed modulo 2^(2*WIDTH); overflow is impossible by construction.
  - Multiplicand shifts left 1 and multiplier shifts right 1.
  - counter += 1.
  - When counter==WIDTH-1 on this step, next state is DONE and the accumulator's final value is loaded into oProduct.
- DONE: oDone=1 for exactly this cycle.
  - Next state is RUN if iStart=1 (back-to-back issue), otherwise IDLE.
- iStart while in RUN: ignored. Latched operands and destination do not change.
- oStall = RUN, or (iStart and state is IDLE or DONE). The processor freezes in the same cycle it issues `IMUL` and stays frozen through the RUN cycles.
- oBusy = (state==RUN).
- oProduct and oDestination update only on completion and otherwise hold. They are never cleared except by Reset.
- Reset asserted in any state, including mid-RUN: next cycle is IDLE with all reset values. No oDone is produced for the aborted operation.

## Timing
- Start accepted at the edge ending cycle N.
- RUN occupies cycles N+1 through N+WIDTH, i.e. exactly WIDTH cycles; fixed latency with no early termination on zero operands.
- DONE occurs in cycle N+WIDTH+1: oDone=1, oProduct valid. Issue-to-done latency is WIDTH+1 cycles (17 at default).
- oStall is high in cycle N (combinationally from iStart) through N+WIDTH. It is low in the DONE cycle unless a new start is issued that cycle.
- Back-to-back issue: a start in the DONE cycle N+WIDTH+1 gives a second done at N+2*WIDTH+2. There is no bubble cycle between the two operations.
- Reset takes priority over iStart in the same cycle.

## Test plan
- Reset, then iStart with iA=7, iB=5, iDestination=R3 code:
  - oStall=1 in the issue cycle.
  - oBusy=1 for 16 cycles.
  - oDone=1 exactly 17 cycles after issue, with oProduct=35 and oDestination=R3 code.
  - oStall=0 during DONE.
- iA=0xFFFF, iB=0xFFFF: oProduct=0xFFFE0001 at done.
- iA=0x1234, iB=0:
  - oProduct=0 at done.
  - Latency is still 17 cycles.
- Start 3×4, then pulse iStart with iA=9, iB=9 during RUN cycle 5:
  - The second start is ignored.
  - Done at the original time with oProduct=12.
  - Only one oDone pulse.
- Start 100×200, assert Reset at RUN cycle 8:
  - Next cycle state is IDLE, oBusy=0, oStall=0, oProduct=0.
  - No oDone within the following 20 cycles.
- Start 6×7, then issue 11×13 in the DONE cycle:
  - First done gives 42.
  - Second done gives 143, exactly 17 cycles after the first.
  - oStall is high continuously from the second issue until the second done.
